max7219_refresh_ctrl: RTL and testbench

Serial display driver between the clock's digit-encoding logic and the MAX7219 8-digit LED controller. After reset it sends the MAX7219 initialisation sequence. On each update strobe it sends the intensity register and all eight raw segment digit registers over the 3-wire serial bus (load, data, clock). Its outputs drive the bidirectional pins used as serial_load, serial_dout and serial_clk.

---
 rtl/max7219_refresh_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_max7219_refresh_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_refresh_ctrl.sv
// MAX7219 serial driver: sends the power-up init sequence, then on each update
// strobe sends the intensity register and all eight raw digit registers.
module max7219_refresh_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_update_stb,
  input  logic [63:0] i_digits,
  input  logic [3:0]  i_intensity,
  output logic        o_serial_load,
  output logic        o_serial_dout,
  output logic        o_serial_clk,
  output logic        o_busy
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       INIT_LAST = 4'd4;
  localparam logic [3:0]       REFR_LAST = 4'd8;
  localparam logic [3:0]       BIT_FIRST = 4'd15;

  typedef enum logic [2:0] {
    ST_RESET_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic             refresh_q, refresh_d;
  logic [3:0]       frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic             half_q, half_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      sreg_q, sreg_d;
  logic             pending_q, pending_d;
  logic [63:0]      digits_q, digits_d;
  logic [3:0]       intensity_q, intensity_d;
  logic             div_end;
  logic             start_refresh;
  logic             load_d, dout_d, sclk_d, busy_d;

  // Power-up frames; the last one carries the live brightness setting.
  function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] intensity);
    case (idx)
      4'd0:    init_word = 16'h0C01;
      4'd1:    init_word = 16'h0F00;
      4'd2:    init_word = 16'h0900;
      4'd3:    init_word = 16'h0B07;
      default: init_word = {8'h0A, 4'h0, intensity};
    endcase
  endfunction

  // Frame 0 is intensity, frames 1..8 map to digit registers 0x01..0x08.
  function automatic logic [15:0] refresh_word(input logic [3:0] idx, input logic [63:0] digits,
                                               input logic [3:0] intensity);
    logic [2:0] sel;
    sel = 3'(idx - 4'd1);
    if (idx == 4'd0) refresh_word = {8'h0A, 4'h0, intensity};
    else             refresh_word = {4'h0, idx, digits[{sel, 3'b000} +: 8]};
  endfunction

  assign div_end = (div_q == DIV_LAST);

  // State and datapath register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_RESET_INIT;
      refresh_q   <= 1'b0;
      frame_q     <= '0;
      bit_q       <= BIT_FIRST;
      half_q      <= 1'b0;
      div_q       <= '0;
      sreg_q      <= '0;
      pending_q   <= 1'b0;
      digits_q    <= '0;
      intensity_q <= '0;
    end else begin
      state_q     <= state_d;
      refresh_q   <= refresh_d;
      frame_q     <= frame_d;
      bit_q       <= bit_d;
      half_q      <= half_d;
      div_q       <= div_d;
      sreg_q      <= sreg_d;
      pending_q   <= pending_d;
      digits_q    <= digits_d;
      intensity_q <= intensity_d;
    end
  end

  // Next-state logic: bit timing, frame sequencing and refresh scheduling.
  always_comb begin
    state_d       = state_q;
    refresh_d     = refresh_q;
    frame_d       = frame_q;
    bit_d         = bit_q;
    half_d        = half_q;
    div_d         = div_q;
    sreg_d        = sreg_q;
    pending_d     = pending_q | i_update_stb;
    digits_d      = digits_q;
    intensity_d   = intensity_q;
    start_refresh = 1'b0;

    case (state_q)
      ST_RESET_INIT: begin
        state_d   = ST_SHIFT;
        refresh_d = 1'b0;
        frame_d   = '0;
        bit_d     = BIT_FIRST;
        half_d    = 1'b0;
        div_d     = '0;
        sreg_d    = init_word(4'd0, i_intensity);
      end
      ST_IDLE: begin
        if (i_update_stb) start_refresh = 1'b1;
      end
      ST_SHIFT: begin
        div_d = div_end ? '0 : div_q + DIV_W'(1);
        if (div_end) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = ST_LOAD;
            end else begin
              bit_d  = bit_q - 4'd1;
              sreg_d = {sreg_q[14:0], 1'b0};
            end
          end
        end
      end
      ST_LOAD: begin
        div_d = div_end ? '0 : div_q + DIV_W'(1);
        if (div_end) state_d = ST_GAP;
      end
      ST_GAP: begin
        div_d = div_end ? '0 : div_q + DIV_W'(1);
        if (div_end) begin
          if (frame_q == (refresh_q ? REFR_LAST : INIT_LAST)) begin
            // A strobe landing on the completion cycle is treated as pending.
            if (pending_q || i_update_stb) start_refresh = 1'b1;
            else                           state_d = ST_IDLE;
          end else begin
            state_d = ST_SHIFT;
            frame_d = frame_q + 4'd1;
            bit_d   = BIT_FIRST;
            half_d  = 1'b0;
            sreg_d  = refresh_q ? refresh_word(frame_q + 4'd1, digits_q, intensity_q)
                                : init_word(frame_q + 4'd1, i_intensity);
          end
        end
      end
      default: state_d = ST_RESET_INIT;
    endcase

    // Snapshot inputs; the first frame is built straight from them.
    if (start_refresh) begin
      state_d     = ST_SHIFT;
      refresh_d   = 1'b1;
      frame_d     = '0;
      bit_d       = BIT_FIRST;
      half_d      = 1'b0;
      div_d       = '0;
      sreg_d      = refresh_word(4'd0, i_digits, i_intensity);
      digits_d    = i_digits;
      intensity_d = i_intensity;
      pending_d   = 1'b0;
    end
  end

  // Output decode from next-state values so the pins are registered yet in step with the state.
  always_comb begin
    load_d = (state_d == ST_LOAD);
    sclk_d = (state_d == ST_SHIFT) && half_d;
    dout_d = (state_d == ST_SHIFT) && sreg_d[15];
    busy_d = (state_d != ST_IDLE) || pending_d;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_serial_load <= 1'b0;
      o_serial_dout <= 1'b0;
      o_serial_clk  <= 1'b0;
      o_busy        <= 1'b1;
    end else begin
      o_serial_load <= load_d;
      o_serial_dout <= dout_d;
      o_serial_clk  <= sclk_d;
      o_busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_max7219_refresh_ctrl.sv
// Bench for max7219_refresh_ctrl: a MAX7219 receiver model and protocol monitor
// checked against frame lists derived from the init/refresh rules.
module tb_max7219_refresh_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rst1_n, stb, stb1;
  logic [63:0] digits;
  logic [3:0]  intensity;
  logic        load4, dout4, sclk4, busy4;
  logic        load1, dout1, sclk1, busy1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] cap0[$], cap1[$], exp_q[$];
  int          st0[$], st1[$];
  logic [7:0]  mreg[16];

  logic        p_load[2], p_clk[2], p_dout[2];
  int          bits[2], highs[2];
  logic [15:0] shreg[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max7219_refresh_ctrl #(.CLK_DIV(4)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_update_stb(stb), .i_digits(digits),
    .i_intensity(intensity), .o_serial_load(load4), .o_serial_dout(dout4),
    .o_serial_clk(sclk4), .o_busy(busy4)
  );

  max7219_refresh_ctrl #(.CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst1_n), .i_update_stb(stb1), .i_digits(digits),
    .i_intensity(intensity), .o_serial_load(load1), .o_serial_dout(dout1),
    .o_serial_clk(sclk1), .o_busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model plus protocol checks for one instance, sampled on the falling edge.
  task automatic mon_step(input int i, input logic rn, input logic ld, input logic dt,
                          input logic sc, input int div);
    logic [15:0] f;
    if (!rn) begin
      bits[i] = 0; highs[i] = 0;
      p_load[i] = 1'b0; p_clk[i] = 1'b0; p_dout[i] = 1'b0;
      return;
    end
    if (ld || sc) check("load_clk_excl", ld & sc, 1'b0);
    if (sc && !p_clk[i]) begin
      check("dout_setup", dt, p_dout[i]);
      shreg[i] = {shreg[i][14:0], dt};
      bits[i]++;
    end
    if (sc && p_clk[i]) check("dout_hold", dt, p_dout[i]);
    if (sc) highs[i]++;
    if (ld && !p_load[i]) begin
      check("bits_per_load", bits[i], 16);
      check("clk_high_cycles", highs[i], 16 * div);
      f = shreg[i];
      if (i == 0) begin
        cap0.push_back(f); st0.push_back(cyc); mreg[int'(f[11:8])] = f[7:0];
      end else begin
        cap1.push_back(f); st1.push_back(cyc);
      end
      bits[i] = 0; highs[i] = 0;
    end
    p_load[i] = ld; p_clk[i] = sc; p_dout[i] = dt;
  endtask

  always @(negedge clk) begin
    mon_step(0, rst_n, load4, dout4, sclk4, 4);
    mon_step(1, rst1_n, load1, dout1, sclk1, 1);
  end

  task automatic add_init(input logic [3:0] it);
    exp_q.push_back(16'h0C01); exp_q.push_back(16'h0F00); exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0B07); exp_q.push_back({8'h0A, 4'h0, it});
  endtask

  task automatic add_refresh(input logic [63:0] d, input logic [3:0] it);
    exp_q.push_back({8'h0A, 4'h0, it});
    for (int k = 0; k < 8; k++) exp_q.push_back({8'(k + 1), d[8*k +: 8]});
  endtask

  task automatic compare_frames(input string tag, input int which, input int spacing);
    logic [15:0] got[$];
    int          st[$];
    if (which == 0) begin got = cap0; st = st0; end
    else            begin got = cap1; st = st1; end
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) check(tag, got[k], exp_q[k]);
    if (spacing != 0)
      for (int k = 1; k < st.size(); k++) check({tag, "_spacing"}, st[k] - st[k-1], spacing);
    exp_q.delete(); cap0.delete(); cap1.delete(); st0.delete(); st1.delete();
  endtask

  // Counts consecutive busy samples starting at the current falling edge.
  task automatic count_busy(input int which, input int budget, output int n);
    n = 0;
    while (((which == 0) ? busy4 : busy1) && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, da, db;
    logic [3:0]  it;
    int          n;

    rst_n = 1'b0; rst1_n = 1'b0; stb = 1'b0; stb1 = 1'b0;
    digits = '0; intensity = 4'h7;
    repeat (3) @(negedge clk);
    check("rst_load", load4, 1'b0);
    check("rst_dout", dout4, 1'b0);
    check("rst_sclk", sclk4, 1'b0);
    check("rst_busy", busy4, 1'b1);
    check("rst_busy_d1", busy1, 1'b1);

    // Power-up init
    rst_n = 1'b1;
    @(negedge clk);
    count_busy(0, 3000, n);
    check("init_busy_cycles", n, 680);
    add_init(4'h7);
    compare_frames("init_frames", 0, 136);

    // Directed refresh; inputs scrambled right after the strobe
    digits = 64'h7E30_6D79_3326_1F7F; intensity = 4'hF; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    digits = {$urandom, $urandom}; intensity = 4'($urandom_range(15, 0));
    count_busy(0, 3000, n);
    check("refresh_busy_cycles", n, 1224);
    add_refresh(64'h7E30_6D79_3326_1F7F, 4'hF);
    compare_frames("refresh_frames", 0, 136);
    check("reg_digit0", mreg[1], 8'h7F);
    check("reg_digit7", mreg[8], 8'h7E);
    check("reg_intensity", mreg[10], 8'h0F);

    // Random refreshes with snapshot check
    for (int r = 0; r < 3; r++) begin
      d = {$urandom, $urandom}; it = 4'($urandom_range(15, 0));
      digits = d; intensity = it; stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      digits = {$urandom, $urandom}; intensity = 4'($urandom_range(15, 0));
      count_busy(0, 3000, n);
      check("rand_busy_cycles", n, 1224);
      add_refresh(d, it);
      compare_frames("rand_frames", 0, 136);
    end

    // Three strobes during a refresh collapse into one back-to-back refresh
    it = intensity; da = {$urandom, $urandom}; db = {$urandom, $urandom};
    digits = da; stb = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy4 && n < 6000) begin
      if (n == 100) begin digits = db; stb = 1'b1; end
      else if (n == 400 || n == 900) stb = 1'b1;
      else stb = 1'b0;
      n++;
      @(negedge clk);
    end
    stb = 1'b0;
    check("multi_busy_cycles", n, 2448);
    add_refresh(da, it); add_refresh(db, it);
    compare_frames("multi_frames", 0, 136);

    // Strobe on the completion cycle
    da = {$urandom, $urandom}; db = {$urandom, $urandom};
    digits = da; stb = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy4 && n < 6000) begin
      if (n == 1223) begin digits = db; stb = 1'b1; end
      else stb = 1'b0;
      n++;
      @(negedge clk);
    end
    stb = 1'b0;
    check("edge_busy_cycles", n, 2448);
    add_refresh(da, it); add_refresh(db, it);
    compare_frames("edge_frames", 0, 136);

    // Reset during bit 9 of the first digit frame, with a pending strobe
    digits = {$urandom, $urandom}; stb = 1'b1;
    @(negedge clk);
    for (n = 0; n < 186; n++) begin
      stb = (n == 50);
      @(negedge clk);
    end
    stb = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_load", load4, 1'b0);
    check("midrst_dout", dout4, 1'b0);
    check("midrst_sclk", sclk4, 1'b0);
    check("midrst_busy", busy4, 1'b1);
    repeat (3) @(negedge clk);
    exp_q.push_back({8'h0A, 4'h0, it});
    compare_frames("midrst_frames", 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    count_busy(0, 3000, n);
    check("reinit_busy_cycles", n, 680);
    add_init(it);
    compare_frames("reinit_frames", 0, 136);

    // CLK_DIV=1 instance
    rst1_n = 1'b1;
    @(negedge clk);
    count_busy(1, 1000, n);
    check("d1_init_busy_cycles", n, 170);
    add_init(it);
    compare_frames("d1_init_frames", 1, 34);
    d = {$urandom, $urandom}; it = 4'($urandom_range(15, 0));
    digits = d; intensity = it; stb1 = 1'b1;
    @(negedge clk);
    stb1 = 1'b0;
    digits = {$urandom, $urandom};
    count_busy(1, 1000, n);
    check("d1_refresh_busy_cycles", n, 306);
    add_refresh(d, it);
    compare_frames("d1_refresh_frames", 1, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
